// File: rtl/riscv_rf_wb_sched_pkg.sv
// Shared register-file widths and the writeback request record used by the
// writeback scheduler slice.
package riscv_rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 1 << RF_ADDR_W;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/riscv_rf_wb_sched_if.sv
// Writeback bus between producers and the scheduler, including the regfile
// write ports and the optional scoreboard signals.
interface riscv_rf_wb_sched_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [ADDR_WIDTH-1:0]         waddr_a_o;
    logic [DATA_WIDTH-1:0]         wdata_a_o;
    logic                          we_a_o;
    logic [ADDR_WIDTH-1:0]         waddr_b_o;
    logic [DATA_WIDTH-1:0]         wdata_b_o;
    logic                          we_b_o;
    logic                          issue_valid_i;
    logic [ADDR_WIDTH-1:0]         issue_rd_i;
    logic [2**ADDR_WIDTH-1:0]      busy_o;
    logic                          sb_err_o;

    modport master (
        output req_valid_i, req_addr_i, req_data_i, issue_valid_i, issue_rd_i,
        input  req_ready_o, waddr_a_o, wdata_a_o, we_a_o,
               waddr_b_o, wdata_b_o, we_b_o, busy_o, sb_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, issue_valid_i, issue_rd_i,
        output req_ready_o, waddr_a_o, wdata_a_o, we_a_o,
               waddr_b_o, wdata_b_o, we_b_o, busy_o, sb_err_o
    );
endinterface

// File: rtl/riscv_wb_rr_pick.sv
// Round-robin first-one finder: scans req upward from start (mod N) and
// returns the first set bit as one-hot grant plus index.
module riscv_wb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          found
);
    logic [IW-1:0] j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(start) + k) % N);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end
endmodule

// File: rtl/riscv_rf_wb_sched.sv
// Dual-port regfile writeback scheduler: round-robin, two grants per cycle,
// never the same rd twice. Optional scoreboard under `RF_SCOREBOARD_EN.
module riscv_rf_wb_sched
    import riscv_rf_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W
) (
    input logic              clk,
    input logic              rst_n,
    riscv_rf_wb_sched_if.slave bus
);
    localparam int IW    = $clog2(NUM_REQ);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    wb_req_t                req [NUM_REQ];
    logic [NUM_REQ-1:0]     x0, elig, elig2, gnt1, gnt2;
    logic [IW-1:0]          idx1, idx2, start2, rr_ptr;
    logic                   found1, found2;
    logic [ADDR_WIDTH-1:0]  addr1, addr2;

    logic                   we_a_p1, we_b_p1;
    logic [ADDR_WIDTH-1:0]  waddr_a_p1, waddr_b_p1;
    logic [DATA_WIDTH-1:0]  wdata_a_p1, wdata_b_p1;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i].addr = bus.req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            req[i].data = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            x0[i]       = bus.req_valid_i[i] && (req[i].addr == '0);
            elig[i]     = bus.req_valid_i[i] && (req[i].addr != '0);
        end
    end

    riscv_wb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_a (
        .req(elig), .start(rr_ptr), .gnt(gnt1), .idx(idx1), .found(found1)
    );

    // Pick 2 scans on from just past pick 1; everything between rr_ptr and
    // pick 1 is already known to be ineligible, so the wrap is harmless.
    assign addr1  = req[idx1].addr;
    assign start2 = wrap_inc(idx1);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig2[i] = elig[i] && !gnt1[i] && (req[i].addr != addr1);
        end
    end

    riscv_wb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_b (
        .req(elig2), .start(start2), .gnt(gnt2), .idx(idx2), .found(found2)
    );

    assign addr2           = req[idx2].addr;
    assign bus.req_ready_o = gnt1 | gnt2 | x0;

    // Stage p0 -> p1: accepted writes land on the regfile ports one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_a_p1    <= 1'b0;
            we_b_p1    <= 1'b0;
            waddr_a_p1 <= '0;
            waddr_b_p1 <= '0;
            wdata_a_p1 <= '0;
            wdata_b_p1 <= '0;
            rr_ptr     <= '0;
        end else begin
            we_a_p1 <= found1;
            we_b_p1 <= found2;
            if (found1) begin
                waddr_a_p1 <= addr1;
                wdata_a_p1 <= req[idx1].data;
                rr_ptr     <= found2 ? wrap_inc(idx2) : wrap_inc(idx1);
            end
            if (found2) begin
                waddr_b_p1 <= addr2;
                wdata_b_p1 <= req[idx2].data;
            end
        end
    end

    assign bus.we_a_o    = we_a_p1;
    assign bus.waddr_a_o = waddr_a_p1;
    assign bus.wdata_a_o = wdata_a_p1;
    assign bus.we_b_o    = we_b_p1;
    assign bus.waddr_b_o = waddr_b_p1;
    assign bus.wdata_b_o = wdata_b_p1;

`ifdef RF_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q, busy_set, busy_clr;
    logic             sb_err_q, err_hit;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        err_hit  = 1'b0;
        if (bus.issue_valid_i && (bus.issue_rd_i != '0)) busy_set[bus.issue_rd_i] = 1'b1;
        if (found1) begin
            busy_clr[addr1] = 1'b1;
            if (!busy_q[addr1]) err_hit = 1'b1;
        end
        if (found2) begin
            busy_clr[addr2] = 1'b1;
            if (!busy_q[addr2]) err_hit = 1'b1;
        end
    end

    // Set beats clear so a re-issue racing the old writeback stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= ((busy_q & ~busy_clr) | busy_set) & {{(NREGS-1){1'b1}}, 1'b0};
            sb_err_q <= sb_err_q | err_hit;
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.sb_err_o = sb_err_q;
`else
    assign bus.busy_o   = '0;
    assign bus.sb_err_o = 1'b0;
`endif
endmodule
